// File: rtl/sll.sv
// Registered logical left shifter with overflow and zero flags, 1-cycle latency.
// No backpressure: a valid input is accepted on every enabled edge.
module sll #(
   parameter int N = 16,
   localparam int AW = $clog2(N)
) (
   input  logic [AW-1:0] amount,
   input  logic [N-1:0]  dataIn,
   output logic [N-1:0]  DataOut,
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          out_valid,
   output logic          overflow,
   output logic          zero
);

   // The shifter runs on a 2N-wide vector so the bits pushed past N-1 land in
   // the upper half, where they are OR-reduced into the overflow flag.
   logic [2*N-1:0] stage [0:AW];
   logic [N-1:0]   shifted;
   logic           spill;
   logic [1:0]     rst_sync;
   logic           run;
   logic           take;

   assign stage[0] = {{N{1'b0}}, dataIn};

   for (genvar k = 0; k < AW; k++) begin : g_stage
      assign stage[k+1] = amount[k] ? (stage[k] << (1 << k)) : stage[k];
   end

   assign shifted = stage[AW][N-1:0];
   assign spill   = |stage[AW][2*N-1:N];

   // Reset asserts immediately but releases capture only after two clean edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign run  = rst_sync[1];
   assign take = in_valid && run;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         DataOut   <= '0;
         out_valid <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b1;
      end else begin
         out_valid <= take;
         if (take) begin
            DataOut  <= shifted;
            overflow <= spill;
            zero     <= ~|shifted;
         end
      end
   end

endmodule

// File: tb/tb_sll.sv
// Bench for sll: directed vectors, back-to-back, reset behaviour and a
// randomized scoreboard run on a 16-bit and a 64-bit instance.
module tb_sll;

   typedef struct {
      logic [63:0] d;
      logic        ov;
      logic        z;
   } exp_t;

   logic        clk;
   logic        rst_n;

   logic [3:0]  a16;
   logic [15:0] d16;
   logic [15:0] o16;
   logic        vi16, vo16, ov16, z16;

   logic [5:0]  a64;
   logic [63:0] d64;
   logic [63:0] o64;
   logic        vi64, vo64, ov64, z64;

   exp_t q16[$];
   exp_t q64[$];

   int pass_cnt = 0;
   int chk_cnt  = 0;

   sll #(.N(16)) dut16 (
      .amount(a16), .dataIn(d16), .DataOut(o16),
      .clk(clk), .rst_n(rst_n), .in_valid(vi16),
      .out_valid(vo16), .overflow(ov16), .zero(z16)
   );

   sll #(.N(64)) dut64 (
      .amount(a64), .dataIn(d64), .DataOut(o64),
      .clk(clk), .rst_n(rst_n), .in_valid(vi64),
      .out_valid(vo64), .overflow(ov64), .zero(z64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bit-by-bit reference: result bit i takes input bit i-amt; the top amt
   // input bits are the ones lost off the end.
   function automatic exp_t model(input int n, input logic [63:0] d, input int amt);
      exp_t e;
      e.d  = '0;
      e.ov = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i >= amt) e.d[i] = d[i-amt];
         if (amt > 0 && i >= n - amt) e.ov = e.ov | d[i];
      end
      e.z = (e.d == 64'd0);
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      vi16 = 0; a16 = '0; d16 = '0;
      vi64 = 0; a64 = '0; d64 = '0;
      tick();
      chk_cnt++;
      if ({o16, vo16, ov16, z16} !== {16'h0, 1'b0, 1'b0, 1'b1})
         $display("FAIL reset16: got d=%h v=%b ov=%b z=%b want d=0000 v=0 ov=0 z=1", o16, vo16, ov16, z16);
      else pass_cnt++;
      chk_cnt++;
      if ({o64, vo64, ov64, z64} !== {64'h0, 1'b0, 1'b0, 1'b1})
         $display("FAIL reset64: got d=%h v=%b ov=%b z=%b want d=0 v=0 ov=0 z=1", o64, vo64, ov64, z64);
      else pass_cnt++;
      // Release between edges with a valid already presented: the first edge must not capture.
      #3 rst_n = 1'b1;
      vi16 = 1; a16 = 4'd1; d16 = 16'h0001;
      tick();
      chk_cnt++;
      if (vo16 !== 1'b0 || o16 !== 16'h0)
         $display("FAIL reset_sync: got v=%b d=%h want v=0 d=0000 on first edge after release", vo16, o16);
      else pass_cnt++;
      vi16 = 0;
      repeat (3) tick();
   endtask

   task automatic test_directed();
      logic [15:0] td [5] = '{16'h0010, 16'h8010, 16'hA5A5, 16'h0001, 16'hF000};
      logic [3:0]  ta [5] = '{4'd4, 4'd4, 4'd0, 4'd15, 4'd4};
      logic [15:0] ed [5] = '{16'h0100, 16'h0100, 16'hA5A5, 16'h8000, 16'h0000};
      logic        eo [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic        ez [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      exp_t e;
      for (int i = 0; i < 5; i++) begin
         vi16 = 1; a16 = ta[i]; d16 = td[i];
         e.d = {48'h0, ed[i]}; e.ov = eo[i]; e.z = ez[i];
         q16.push_back(e);
         tick();
         e = q16.pop_front();
         chk_cnt++;
         if ({vo16, o16, ov16, z16} !== {1'b1, e.d[15:0], e.ov, e.z})
            $display("FAIL directed%0d: got v=%b d=%h ov=%b z=%b want v=1 d=%h ov=%b z=%b",
                     i, vo16, o16, ov16, z16, e.d[15:0], e.ov, e.z);
         else pass_cnt++;
      end
      vi16 = 0;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [15:0] td [3] = '{16'h0003, 16'h00FF, 16'hC001};
      logic [3:0]  ta [3] = '{4'd1, 4'd8, 4'd2};
      logic [15:0] ed [3] = '{16'h0006, 16'hFF00, 16'h0004};
      logic        eo [3] = '{1'b0, 1'b0, 1'b1};
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         vi16 = 1; a16 = ta[i]; d16 = td[i];
         e.d = {48'h0, ed[i]}; e.ov = eo[i]; e.z = 1'b0;
         q16.push_back(e);
         tick();
         e = q16.pop_front();
         chk_cnt++;
         if ({vo16, o16, ov16, z16} !== {1'b1, e.d[15:0], e.ov, e.z})
            $display("FAIL b2b%0d: got v=%b d=%h ov=%b z=%b want v=1 d=%h ov=%b z=%b",
                     i, vo16, o16, ov16, z16, e.d[15:0], e.ov, e.z);
         else pass_cnt++;
      end
      vi16 = 0; a16 = 4'd0; d16 = 16'hFFFF;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk_cnt++;
         if ({vo16, o16, ov16, z16} !== {1'b0, 16'h0004, 1'b1, 1'b0})
            $display("FAIL b2b_hold%0d: got v=%b d=%h ov=%b z=%b want v=0 d=0004 ov=1 z=0",
                     i, vo16, o16, ov16, z16);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_pending();
      vi16 = 1; a16 = 4'd3; d16 = 16'h0101;
      tick();
      // Next input is presented, then reset lands mid-period before it is sampled.
      a16 = 4'd1; d16 = 16'h0202;
      #2 rst_n = 1'b0;
      #1;
      chk_cnt++;
      if ({vo16, o16, ov16, z16} !== {1'b0, 16'h0, 1'b0, 1'b1})
         $display("FAIL reset_async: got v=%b d=%h ov=%b z=%b want v=0 d=0000 ov=0 z=1", vo16, o16, ov16, z16);
      else pass_cnt++;
      vi16 = 0;
      tick();
      #2 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_cnt++;
         if (vo16 !== 1'b0 || o16 !== 16'h0)
            $display("FAIL reset_discard%0d: got v=%b d=%h want v=0 d=0000", i, vo16, o16);
         else pass_cnt++;
      end
   endtask

   task automatic test_random();
      exp_t e, last16, last64;
      logic v16, v64;
      for (int i = 0; i < 400; i++) begin
         v16 = (i < 64) ? 1'b1 : ($urandom_range(3) != 0);
         v64 = (i < 64) ? 1'b1 : ($urandom_range(3) != 0);
         vi16 = v16;
         a16 = (i < 64) ? 4'(i % 16) : 4'($urandom_range(15));
         d16 = 16'($urandom);
         if (i % 7 == 3) d16 = d16 & 16'h00F0;
         vi64 = v64;
         a64 = (i < 64) ? 6'(i) : 6'($urandom_range(63));
         d64 = {$urandom, $urandom};
         if (i % 5 == 2) d64 = d64 & 64'h0000_0000_0000_FF00;
         if (v16) q16.push_back(model(16, {48'h0, d16}, int'(a16)));
         if (v64) q64.push_back(model(64, d64, int'(a64)));
         tick();
         if (v16) last16 = q16.pop_front();
         if (v64) last64 = q64.pop_front();
         chk_cnt++;
         if ({vo16, o16, ov16, z16} !== {v16, last16.d[15:0], last16.ov, last16.z})
            $display("FAIL rand16 cyc%0d: got v=%b d=%h ov=%b z=%b want v=%b d=%h ov=%b z=%b",
                     i, vo16, o16, ov16, z16, v16, last16.d[15:0], last16.ov, last16.z);
         else pass_cnt++;
         chk_cnt++;
         if ({vo64, o64, ov64, z64} !== {v64, last64.d, last64.ov, last64.z})
            $display("FAIL rand64 cyc%0d: got v=%b d=%h ov=%b z=%b want v=%b d=%h ov=%b z=%b",
                     i, vo64, o64, ov64, z64, v64, last64.d, last64.ov, last64.z);
         else pass_cnt++;
      end
      vi16 = 0;
      vi64 = 0;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_pending();
      test_random();
      tick();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
